// File: rtl/sd_sector_writer_if.sv
// Byte-FIFO read side plus sd_controller write-port bundle for the sector writer.
// master = sd_sector_writer; slave = FIFO / sd_controller side.
interface sd_sector_writer_if;
    logic        fifo_empty;
    logic [7:0]  fifo_dout;
    logic        fifo_rd_en;
    logic        sd_ready;
    logic        sd_ready_for_next_byte;
    logic        sd_wr;
    logic [31:0] sd_addr;
    logic [7:0]  sd_din;

    modport master (
        input  fifo_empty, fifo_dout, sd_ready, sd_ready_for_next_byte,
        output fifo_rd_en, sd_wr, sd_addr, sd_din
    );

    modport slave (
        output fifo_empty, fifo_dout, sd_ready, sd_ready_for_next_byte,
        input  fifo_rd_en, sd_wr, sd_addr, sd_din
    );
endinterface

// File: rtl/sd_sector_writer.sv
// Drains a FWFT byte FIFO into whole sd_controller sector writes; sd_wr 2 cycles after start, paced by ready/rfnb edges.
// Empty FIFO is padded, never stalled on. Optional watchdog under SD_WR_TIMEOUT_EN.
module sd_sector_writer #(
    parameter int         SECTOR_BYTES   = 512,
    parameter logic [7:0] PAD_BYTE       = 8'h00,
    parameter int         TIMEOUT_CYCLES = 2_000_000
) (
    input  logic               clk_25mhz,
    input  logic               reset,
    input  logic               start,
    input  logic [31:0]        base_addr,
    input  logic [15:0]        num_sectors,
    sd_sector_writer_if.master bus,
    output logic               busy,
    output logic               done,
    output logic               underflow,
    output logic [15:0]        sectors_written,
    output logic               timeout_err
);

    typedef enum logic [2:0] {IDLE, LOAD, ISSUE, STREAM, WAIT_DONE, NEXT} state_t;

    state_t      state, state_d;
    logic [31:0] addr;
    logic [7:0]  din;
    logic [15:0] num_q;
    logic [9:0]  byte_cnt;
    logic        rfnb_q, fetch_pend, zero_pend;
    logic        fetch, wr, rise, last_byte, last_sector, accept, wd_hit;

    assign rise        = bus.sd_ready_for_next_byte && !rfnb_q;
    assign last_byte   = (byte_cnt == 10'(SECTOR_BYTES - 1));
    assign last_sector = ((sectors_written + 16'd1) == num_q);
    assign accept      = (state == IDLE) && start && !busy;

    always_comb begin
        state_d = state;
        fetch   = 1'b0;
        wr      = 1'b0;
        case (state)
            IDLE:      if (accept && num_sectors != 16'd0) state_d = LOAD;
            LOAD: begin
                fetch   = 1'b1;
                state_d = ISSUE;
            end
            ISSUE: if (bus.sd_ready) begin
                wr      = 1'b1;
                state_d = STREAM;
            end
            STREAM: begin
                fetch = fetch_pend;
                if (rise && last_byte) state_d = WAIT_DONE;
            end
            WAIT_DONE: if (bus.sd_ready) state_d = NEXT;
            NEXT:      state_d = last_sector ? IDLE : LOAD;
            default:   state_d = IDLE;
        endcase
        if (wd_hit) begin
            state_d = IDLE;
            fetch   = 1'b0;
            wr      = 1'b0;
        end
        // Reset must silence the combinational strobes in the very cycle it is applied
        if (reset) begin
            fetch = 1'b0;
            wr    = 1'b0;
        end
    end

    assign bus.fifo_rd_en = fetch && !bus.fifo_empty;
    assign bus.sd_wr      = wr;
    assign bus.sd_addr    = addr;
    assign bus.sd_din     = din;

    always_ff @(posedge clk_25mhz) begin
        if (reset) begin
            state           <= IDLE;
            addr            <= '0;
            din             <= '0;
            num_q           <= '0;
            byte_cnt        <= '0;
            rfnb_q          <= 1'b0;
            fetch_pend      <= 1'b0;
            zero_pend       <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            underflow       <= 1'b0;
            sectors_written <= '0;
        end else begin
            state      <= state_d;
            rfnb_q     <= bus.sd_ready_for_next_byte;
            done       <= 1'b0;
            fetch_pend <= 1'b0;
            if (fetch) begin
                if (!bus.fifo_empty) begin
                    din <= bus.fifo_dout;
                end else begin
                    din       <= PAD_BYTE;
                    underflow <= 1'b1;
                end
            end
            case (state)
                IDLE: begin
                    if (zero_pend) begin
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        zero_pend <= 1'b0;
                    end else if (accept) begin
                        addr            <= base_addr;
                        num_q           <= num_sectors;
                        underflow       <= 1'b0;
                        sectors_written <= '0;
                        busy            <= 1'b1;
                        zero_pend       <= (num_sectors == 16'd0);
                    end
                end
                ISSUE: if (wr) byte_cnt <= '0;
                STREAM: if (rise) begin
                    byte_cnt   <= byte_cnt + 10'd1;
                    fetch_pend <= !last_byte && !wd_hit;
                end
                NEXT: begin
                    sectors_written <= sectors_written + 16'd1;
                    addr            <= addr + 32'(SECTOR_BYTES);
                    if (last_sector) begin
                        done <= 1'b1;
                        busy <= 1'b0;
                    end
                end
                default: ;
            endcase
            if (wd_hit) begin
                done <= 1'b1;
                busy <= 1'b0;
            end
        end
    end

`ifdef SD_WR_TIMEOUT_EN
    logic [23:0] wd;
    logic        wd_active;

    assign wd_active = (state == ISSUE) || (state == STREAM) || (state == WAIT_DONE);
    assign wd_hit    = wd_active && (wd == 24'(TIMEOUT_CYCLES - 1));

    // Any forward progress (state change or consumed byte) restarts the watchdog
    always_ff @(posedge clk_25mhz) begin
        if (reset) begin
            wd          <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (!wd_active || state_d != state || (state == STREAM && rise))
                wd <= '0;
            else
                wd <= wd + 24'd1;
            if (accept)
                timeout_err <= 1'b0;
            else if (wd_hit)
                timeout_err <= 1'b1;
        end
    end
`else
    assign wd_hit      = 1'b0;
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_sd_sector_writer.sv
// Scoreboarded bench: FIFO and sd_controller models feed the writer; monitors pop expected addresses, bytes and done status.
module tb_sd_sector_writer;
    localparam int SB = 512;

    typedef struct packed {
        logic [15:0] sw;
        logic        uf;
        logic        to;
    } done_exp_t;

    logic        clk_25mhz = 1'b0;
    logic        reset, start;
    logic [31:0] base_addr;
    logic [15:0] num_sectors;
    logic        busy, done, underflow, timeout_err;
    logic [15:0] sectors_written;

    sd_sector_writer_if bus();

    sd_sector_writer #(
        .SECTOR_BYTES  (SB),
        .PAD_BYTE      (8'h00),
        .TIMEOUT_CYCLES(1000)
    ) dut (
        .clk_25mhz      (clk_25mhz),
        .reset          (reset),
        .start          (start),
        .base_addr      (base_addr),
        .num_sectors    (num_sectors),
        .bus            (bus),
        .busy           (busy),
        .done           (done),
        .underflow      (underflow),
        .sectors_written(sectors_written),
        .timeout_err    (timeout_err)
    );

    always #20 clk_25mhz = ~clk_25mhz;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pops = 0;
    int wr_cnt = 0;
    int wr_cyc = 0;
    int bytes_served = 0;
    bit abort = 0;
    bit stall = 0;
    bit ctrl_idle = 1;
    bit pop_pend = 0;

    logic [7:0]  fifo_q[$];
    logic [7:0]  exp_byte[$];
    logic [31:0] exp_addr[$];
    done_exp_t   exp_done[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic done_exp_t mk(input logic [15:0] sw, input logic uf, input logic to);
        done_exp_t d;
        d.sw = sw;
        d.uf = uf;
        d.to = to;
        return d;
    endfunction

    always @(posedge clk_25mhz) cyc++;

    // FWFT FIFO model: a pop seen mid-cycle takes effect at the following edge
    always begin
        @(negedge clk_25mhz);
        if (pop_pend) begin
            if (fifo_q.size() > 0) void'(fifo_q.pop_front());
            pops++;
        end
        bus.fifo_empty = (fifo_q.size() == 0);
        bus.fifo_dout  = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
        #5;
        pop_pend = bus.fifo_rd_en;
        if (bus.fifo_rd_en && bus.fifo_empty) chk("pop_while_empty", 1, 0);
    end

    // sd_controller model and address/byte monitor
    always begin
        @(negedge clk_25mhz);
        #5;
        if (bus.sd_wr) begin
            wr_cnt++;
            wr_cyc = cyc;
            if (exp_addr.size() == 0) chk("unexpected_sd_wr", 1, 0);
            else chk("sd_addr", bus.sd_addr, exp_addr.pop_front());
            ctrl_idle = 0;
            @(negedge clk_25mhz);
            bus.sd_ready = 1'b0;
            if (stall) begin
                while (stall) @(negedge clk_25mhz);
            end else begin
                for (int i = 0; i < SB && !abort; i++) begin
                    repeat (2) @(negedge clk_25mhz);
                    if (abort) break;
                    bus.sd_ready_for_next_byte = 1'b1;
                    bytes_served++;
                    if (exp_byte.size() == 0) chk("unexpected_byte", 1, 0);
                    else chk("sd_din", {24'd0, bus.sd_din}, {24'd0, exp_byte.pop_front()});
                    @(negedge clk_25mhz);
                    bus.sd_ready_for_next_byte = 1'b0;
                end
            end
            if (!abort) repeat (3) @(negedge clk_25mhz);
            bus.sd_ready = 1'b1;
            ctrl_idle = 1;
        end
    end

    // done monitor
    always begin
        done_exp_t d;
        @(negedge clk_25mhz);
        #5;
        if (done) begin
            if (exp_done.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                d = exp_done.pop_front();
                chk("done_sectors_written", {16'd0, sectors_written}, {16'd0, d.sw});
                chk("done_underflow", {31'd0, underflow}, {31'd0, d.uf});
                chk("done_timeout_err", {31'd0, timeout_err}, {31'd0, d.to});
                chk("done_busy", {31'd0, busy}, 32'd0);
            end
        end
    end

    task automatic fill(input int n, input int mul, input int add);
        for (int i = 0; i < n; i++) begin
            fifo_q.push_back(8'((i * mul + add) % 256));
            exp_byte.push_back(8'((i * mul + add) % 256));
        end
    endtask

    task automatic do_start(input logic [31:0] a, input logic [15:0] n);
        @(negedge clk_25mhz);
        base_addr   = a;
        num_sectors = n;
        start       = 1'b1;
        @(negedge clk_25mhz);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cycles, output int busy_low);
        cycles   = 0;
        busy_low = 0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk_25mhz);
            #5;
            cycles++;
            if (done) return;
            if (!busy) busy_low++;
        end
        chk("done_wait_expired", 0, 1);
    endtask

    task automatic check_quiet(input string p);
        chk({p, "_busy"}, {31'd0, busy}, 32'd0);
        chk({p, "_done"}, {31'd0, done}, 32'd0);
        chk({p, "_underflow"}, {31'd0, underflow}, 32'd0);
        chk({p, "_sectors_written"}, {16'd0, sectors_written}, 32'd0);
        chk({p, "_timeout_err"}, {31'd0, timeout_err}, 32'd0);
        chk({p, "_sd_wr"}, {31'd0, bus.sd_wr}, 32'd0);
        chk({p, "_fifo_rd_en"}, {31'd0, bus.fifo_rd_en}, 32'd0);
        chk({p, "_sd_addr"}, bus.sd_addr, 32'd0);
        chk({p, "_sd_din"}, {24'd0, bus.sd_din}, 32'd0);
    endtask

    initial begin
        #(40 * 60000);
        $display("FAIL global_timeout: simulation still running at cycle %0d", cyc);
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        int c, bl, t0;
        reset = 1'b1;
        start = 1'b0;
        base_addr = '0;
        num_sectors = '0;
        bus.fifo_empty = 1'b1;
        bus.fifo_dout = 8'h00;
        bus.sd_ready = 1'b1;
        bus.sd_ready_for_next_byte = 1'b0;
        repeat (3) @(negedge clk_25mhz);
        #5;
        check_quiet("reset");
        @(negedge clk_25mhz);
        reset = 1'b0;

        // one sector at odd base address, bytes 0..255,0..255
        pops = 0; wr_cnt = 0;
        fill(512, 1, 0);
        exp_addr.push_back(32'd15);
        exp_done.push_back(mk(16'd1, 1'b0, 1'b0));
        do_start(32'd15, 16'd1);
        t0 = cyc;
        wait_done(6000, c, bl);
        chk("t1_wr_latency", 32'(wr_cyc - t0), 32'd1);
        chk("t1_pops", pops, 512);
        chk("t1_wr_cnt", wr_cnt, 1);
        chk("t1_busy_low", bl, 0);
        repeat (4) @(negedge clk_25mhz);

        // three sectors, address stride 512
        pops = 0; wr_cnt = 0;
        fill(1536, 3, 1);
        exp_addr.push_back(32'd15);
        exp_addr.push_back(32'd527);
        exp_addr.push_back(32'd1039);
        exp_done.push_back(mk(16'd3, 1'b0, 1'b0));
        do_start(32'd15, 16'd3);
        wait_done(15000, c, bl);
        chk("t2_pops", pops, 1536);
        chk("t2_wr_cnt", wr_cnt, 3);
        chk("t2_busy_low", bl, 0);
        repeat (4) @(negedge clk_25mhz);

        // FIFO runs dry after 500 bytes: 12 pad bytes
        pops = 0; wr_cnt = 0;
        fill(500, 7, 3);
        for (int i = 0; i < 12; i++) exp_byte.push_back(8'h00);
        exp_addr.push_back(32'd4096);
        exp_done.push_back(mk(16'd1, 1'b1, 1'b0));
        do_start(32'd4096, 16'd1);
        wait_done(6000, c, bl);
        chk("t3_pops", pops, 500);
        chk("t3_wr_cnt", wr_cnt, 1);
        repeat (4) @(negedge clk_25mhz);

        // zero-sector job: busy one cycle, then done
        wr_cnt = 0;
        exp_done.push_back(mk(16'd0, 1'b0, 1'b0));
        do_start(32'd77, 16'd0);
        #5;
        chk("t4_busy_after_start", {31'd0, busy}, 32'd1);
        chk("t4_done_early", {31'd0, done}, 32'd0);
        @(negedge clk_25mhz); #5;
        chk("t4_done_pulse", {31'd0, done}, 32'd1);
        chk("t4_busy_cleared", {31'd0, busy}, 32'd0);
        @(negedge clk_25mhz); #5;
        chk("t4_done_one_cycle", {31'd0, done}, 32'd0);
        chk("t4_busy_low", {31'd0, busy}, 32'd0);
        chk("t4_wr_cnt", wr_cnt, 0);
        repeat (2) @(negedge clk_25mhz);

        // reset mid-sector after 200 bytes, then a fresh job
        wr_cnt = 0; bytes_served = 0;
        fill(512, 5, 9);
        exp_addr.push_back(32'd100);
        do_start(32'd100, 16'd1);
        for (int k = 0; k < 3000 && bytes_served < 200; k++) @(negedge clk_25mhz);
        chk("t5_bytes_before_reset", bytes_served, 200);
        @(negedge clk_25mhz);
        reset = 1'b1;
        abort = 1'b1;
        @(negedge clk_25mhz); #5;
        check_quiet("t5_reset");
        @(negedge clk_25mhz);
        reset = 1'b0;
        for (int k = 0; k < 20 && !ctrl_idle; k++) @(negedge clk_25mhz);
        chk("t5_ctrl_idle", {31'd0, ctrl_idle}, 32'd1);
        abort = 1'b0;
        exp_byte.delete();
        fifo_q.delete();
        repeat (2) @(negedge clk_25mhz);
        pops = 0; wr_cnt = 0;
        fill(512, 1, 0);
        exp_addr.push_back(32'd100);
        exp_done.push_back(mk(16'd1, 1'b0, 1'b0));
        do_start(32'd100, 16'd1);
        wait_done(6000, c, bl);
        chk("t5_pops", pops, 512);
        chk("t5_wr_cnt", wr_cnt, 1);
        repeat (4) @(negedge clk_25mhz);

`ifdef SD_WR_TIMEOUT_EN
        // controller stalls with ready low after sd_wr
        pops = 0; wr_cnt = 0;
        stall = 1'b1;
        fifo_q.push_back(8'hAA);
        fifo_q.push_back(8'hBB);
        exp_addr.push_back(32'd200);
        exp_done.push_back(mk(16'd0, 1'b0, 1'b1));
        do_start(32'd200, 16'd1);
        wait_done(3000, c, bl);
        chk("t6_timeout_latency_near_1000", {31'd0, (c >= 990 && c <= 1010)}, 32'd1);
        chk("t6_pops", pops, 1);
        chk("t6_wr_cnt", wr_cnt, 1);
        stall = 1'b0;
        for (int k = 0; k < 20 && !ctrl_idle; k++) @(negedge clk_25mhz);
        fifo_q.delete();
        repeat (4) @(negedge clk_25mhz);
`endif

        chk("left_exp_addr", exp_addr.size(), 0);
        chk("left_exp_byte", exp_byte.size(), 0);
        chk("left_exp_done", exp_done.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sd_sector_writer.md
Name: sd_sector_writer

Overview:
Write-direction companion to the SD read path: drains a byte FIFO and pushes whole 512-byte sectors through the sd_controller write interface (wr, din, ready_for_next_byte, ready, address). Used to save board state to the card starting at a given address. Sits between the board-state FIFO read side and sd_controller, all in the clk_25mhz domain.

Parameters:
SECTOR_BYTES, 512, bytes per write operation; also the address stride between sectors.
PAD_BYTE, 8'h00, byte sent when the FIFO is empty at the moment a byte is needed.
TIMEOUT_CYCLES, 2_000_000, watchdog limit (used only with the optional feature).

Ports:
clk_25mhz  input  1  system clock, 25 MHz
reset  input  1  synchronous, active-high
start  input  1  one-cycle request; sampled only in IDLE
base_addr  input  32  byte address of the first sector; latched on start
num_sectors  input  16  sectors to write; latched on start
fifo_empty  input  1  FWFT FIFO empty flag
fifo_dout  input  8  FWFT FIFO head byte, valid when !fifo_empty
fifo_rd_en  output  1  one-cycle pop of the FIFO head
sd_ready  input  1  sd_controller idle/ready
sd_ready_for_next_byte  input  1  sd_controller has latched sd_din (level; rising edge = byte consumed)
sd_wr  output  1  write-sector request to sd_controller
sd_addr  output  32  sector address to sd_controller
sd_din  output  8  byte to sd_controller
busy  output  1  high from accepted start until done
done  output  1  one-cycle pulse at job end
underflow  output  1  sticky: at least one PAD_BYTE was sent this job
sectors_written  output  16  completed sectors in the current/last job
timeout_err  output  1  sticky watchdog error (always 0 without the macro)

Behaviour:
- Reset: state IDLE; every output 0; internal edge register and byte counter 0. Reset mid-sector abandons the sector immediately; sd_wr drops the same cycle.
- States: IDLE, LOAD, ISSUE, STREAM, WAIT_DONE, NEXT.
- IDLE: on start, latch base_addr into sd_addr and num_sectors; clear underflow, sectors_written, timeout_err; set busy. If num_sectors==0, pulse done next cycle, clear busy, stay IDLE. Otherwise go to LOAD.
- Fetch rule (used by LOAD and STREAM): if !fifo_empty, sd_din<=fifo_dout and fifo_rd_en=1 for one cycle. Else sd_din<=PAD_BYTE, underflow<=1, no pop. fifo_rd_en is never asserted while fifo_empty and at most once per byte.
- LOAD: fetch byte 1 of the sector; go to ISSUE.
- ISSUE: wait for sd_ready=1, then assert sd_wr for exactly one cycle with sd_addr stable; clear byte_cnt; go to STREAM. Latency: sd_wr is asserted 2 cycles after start when sd_ready is already high.
- STREAM: detect rising edges of sd_ready_for_next_byte from a registered previous value. Each edge increments byte_cnt (10-bit). After edge k < SECTOR_BYTES, fetch byte k+1 on the next cycle. Edge SECTOR_BYTES goes to WAIT_DONE without fetching. This gives exactly 512 fetches per sector.
- WAIT_DONE: wait for sd_ready=1, then go to NEXT.
- NEXT: sectors_written+=1 and sd_addr+=SECTOR_BYTES (32-bit wrap). If the new count equals num_sectors, pulse done, clear busy, go to IDLE. Otherwise go to LOAD.
- start while busy is ignored.
- Rising edges of sd_ready_for_next_byte outside STREAM are ignored.
- sd_addr, sd_din and sectors_written hold their values after done.

Optional Feature:
Macro SD_WR_TIMEOUT_EN.
- Defined: a 24-bit watchdog counts cycles spent in ISSUE, STREAM or WAIT_DONE and resets on every state change or counted edge. On reaching TIMEOUT_CYCLES it sets timeout_err, drops sd_wr, pulses done, clears busy and returns to IDLE. sectors_written keeps the completed count.
- Undefined: no counter is built; timeout_err is tied to 0; the block waits indefinitely.

Test Plan:
- base_addr=15, num_sectors=1, FIFO preloaded with 512 bytes 0..255,0..255, controller model pulses rfnb 512 times then raises ready: captured bytes match, sd_wr pulses once with sd_addr=15, 512 pops, done pulses, sectors_written=1, underflow=0.
- num_sectors=3, 1536 bytes available: three sd_wr pulses at addresses 15, 527, 1039; done only after the third sector; busy high throughout.
- FIFO holds only 500 bytes, num_sectors=1: bytes 501-512 are 8'h00, underflow=1, exactly 500 pops, done still pulses.
- num_sectors=0: done pulses one cycle after start, sd_wr never asserted, busy low again after that cycle.
- Assert reset after 200 bytes of a sector: next cycle all outputs 0 and state IDLE; a new start writes a fresh sector from base_addr.
- With SD_WR_TIMEOUT_EN defined and TIMEOUT_CYCLES=1000, controller stalls with ready low after sd_wr: timeout_err=1 and done pulse about 1000 cycles later, sectors_written=0.
